// File: rtl/alu_ctrl_decoder_pkg.sv
// alu_ctrl_pkg: shared opcodes, alu_bus bit indices, modifier encodings and FSM/latency enums.
// Latency: none (declarations and a pure helper function only).
// Backpressure: not applicable.
package alu_ctrl_pkg;

    localparam int BUS_W = 15;

    // SimpleRisc opcodes
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    // alu_bus one-hot bit positions
    localparam int BUS_ADD = 0;
    localparam int BUS_SUB = 1;
    localparam int BUS_MUL = 2;
    localparam int BUS_DIV = 3;
    localparam int BUS_MOD = 4;
    localparam int BUS_CMP = 5;
    localparam int BUS_AND = 6;
    localparam int BUS_OR  = 7;
    localparam int BUS_NOT = 8;
    localparam int BUS_MOV = 9;
    localparam int BUS_LSL = 10;
    localparam int BUS_LSR = 11;
    localparam int BUS_ASR = 12;
    localparam int BUS_LD  = 13;
    localparam int BUS_ST  = 14;

    // Immediate modifier encodings
    localparam logic [1:0] MOD_SEXT = 2'b00;
    localparam logic [1:0] MOD_ZEXT = 2'b01;
    localparam logic [1:0] MOD_HIGH = 2'b10;
    localparam logic [1:0] MOD_RSV  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        LAT_ONE,
        LAT_MUL,
        LAT_DIV
    } lat_class_t;

    // Reserved modifier falls back to sign extension.
    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [1:0] modifier);
        logic [31:0] ext;
        case (modifier)
            MOD_ZEXT: ext = {16'h0000, imm};
            MOD_HIGH: ext = {imm, 16'h0000};
            default:  ext = {{16{imm[15]}}, imm};
        endcase
        return ext;
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder_if.sv
// alu_ctrl_decoder_if: instruction-in / ALU-control-out bundle between issue logic and decode stage.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the instruction side, out_valid/out_ready on the completion side.
interface alu_ctrl_decoder_if;
    import alu_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [BUS_W-1:0] alu_bus;
    logic             use_imm;
    logic [31:0]      imm_ext;
    logic [3:0]       rd;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic             out_valid;
    logic             out_ready;
    logic             illegal;

    // Producer of instructions / consumer of completions
    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, alu_bus, use_imm, imm_ext, rd, rs1, rs2, out_valid, illegal
    );

    // The decode stage itself
    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, alu_bus, use_imm, imm_ext, rd, rs1, rs2, out_valid, illegal
    );

endinterface

// File: rtl/alu_ctrl_decoder_alu_bus_encoder.sv
// alu_bus_encoder: opcode -> one-hot alu_bus, latency class and legality (trap with ALU_CTRL_ILLEGAL_TRAP_EN).
// Latency: purely combinational.
// Backpressure: none.
module alu_bus_encoder
    import alu_ctrl_pkg::*;
(
    input  logic [4:0]       opcode,
    input  logic [1:0]       modifier,
    output logic [BUS_W-1:0] alu_bus,
    output lat_class_t       lat_class,
    output logic             legal
);

    logic             known;
    logic [BUS_W-1:0] raw_bus;
    lat_class_t       raw_lat;

    // Raw opcode decode; nop and branches are known but drive no ALU op.
    always_comb begin
        raw_bus = '0;
        raw_lat = LAT_ONE;
        known   = 1'b1;
        case (opcode)
            OP_ADD: raw_bus[BUS_ADD] = 1'b1;
            OP_SUB: raw_bus[BUS_SUB] = 1'b1;
            OP_MUL: begin
                raw_bus[BUS_MUL] = 1'b1;
                raw_lat          = LAT_MUL;
            end
            OP_DIV: begin
                raw_bus[BUS_DIV] = 1'b1;
                raw_lat          = LAT_DIV;
            end
            OP_MOD: begin
                raw_bus[BUS_MOD] = 1'b1;
                raw_lat          = LAT_DIV;
            end
            OP_CMP: raw_bus[BUS_CMP] = 1'b1;
            OP_AND: raw_bus[BUS_AND] = 1'b1;
            OP_OR:  raw_bus[BUS_OR]  = 1'b1;
            OP_NOT: raw_bus[BUS_NOT] = 1'b1;
            OP_MOV: raw_bus[BUS_MOV] = 1'b1;
            OP_LSL: raw_bus[BUS_LSL] = 1'b1;
            OP_LSR: raw_bus[BUS_LSR] = 1'b1;
            OP_ASR: raw_bus[BUS_ASR] = 1'b1;
            OP_LD:  raw_bus[BUS_LD]  = 1'b1;
            OP_ST:  raw_bus[BUS_ST]  = 1'b1;
            OP_NOP, OP_BEQ, OP_BGT, OP_B, OP_CALL, OP_RET: raw_bus = '0;
            default: known = 1'b0;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    // Undefined opcodes and the reserved modifier trap.
    assign legal = known && (modifier != MOD_RSV);
`else
    // Without the trap, undefined opcodes already fall through as nop.
    logic unused_decode;
    assign unused_decode = ^{known, modifier};
    assign legal         = 1'b1;
`endif

    // An illegal op never reaches the ALU and completes in a single cycle.
    assign alu_bus   = legal ? raw_bus : '0;
    assign lat_class = legal ? raw_lat : LAT_ONE;

endmodule

// File: rtl/alu_ctrl_decoder.sv
// alu_ctrl_decoder: registered decode/issue stage driving ALU controls (illegal trap with ALU_CTRL_ILLEGAL_TRAP_EN).
// Latency: controls valid the cycle after accept; out_valid lat cycles after the accept edge (MUL_LAT, DIV_LAT, else 1).
// Backpressure: holds everything stable in DONE while out_ready is low; in_ready follows out_ready in DONE.
module alu_ctrl_decoder
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_ctrl_decoder_if.slave ctrl
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    // Instruction fields
    logic [4:0]  opcode;
    logic        ibit;
    logic [3:0]  rd_f;
    logic [3:0]  rs1_f;
    logic [3:0]  rs2_f;
    logic [1:0]  modifier;
    logic [15:0] imm;

    assign opcode   = ctrl.in_instr[31:27];
    assign ibit     = ctrl.in_instr[26];
    assign rd_f     = ctrl.in_instr[25:22];
    assign rs1_f    = ctrl.in_instr[21:18];
    assign rs2_f    = ctrl.in_instr[17:14];
    assign modifier = ctrl.in_instr[17:16];
    assign imm      = ctrl.in_instr[15:0];

    logic [BUS_W-1:0] dec_bus;
    lat_class_t       dec_lat;
    logic             dec_legal;
    logic [CNT_W-1:0] lat_m1;

    alu_bus_encoder u_encoder (
        .opcode    (opcode),
        .modifier  (modifier),
        .alu_bus   (dec_bus),
        .lat_class (dec_lat),
        .legal     (dec_legal)
    );

    // Counter preload is the op latency minus one (the accept cycle itself counts).
    always_comb begin
        lat_m1 = '0;
        case (dec_lat)
            LAT_MUL: lat_m1 = CNT_W'(MUL_LAT - 1);
            LAT_DIV: lat_m1 = CNT_W'(DIV_LAT - 1);
            default: lat_m1 = '0;
        endcase
    end

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             ready;
    logic             accept;

    // Next-state, counter and in_ready; an accept overrides whatever the state alone would do.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ready      = 1'b0;
        case (state)
            IDLE: ready = 1'b1;
            EXEC: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                ready = ctrl.out_ready;
                if (ctrl.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        accept = ready && rst_n && ctrl.in_valid;
        if (accept) begin
            state_next = (lat_m1 == '0) ? DONE : EXEC;
            cnt_next   = lat_m1;
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    logic [BUS_W-1:0] bus_q;
    logic             use_imm_q;
    logic [31:0]      imm_q;
    logic [3:0]       rd_q;
    logic [3:0]       rs1_q;
    logic [3:0]       rs2_q;

    // Held op fields: loaded on accept; alu_bus drops to zero when the stage goes idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_q     <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
        end else if (accept) begin
            bus_q     <= dec_bus;
            use_imm_q <= ibit;
            imm_q     <= extend_imm(imm, modifier);
            rd_q      <= rd_f;
            rs1_q     <= rs1_f;
            rs2_q     <= rs2_f;
        end else if (state == DONE && ctrl.out_ready) begin
            bus_q <= '0;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Trap flag travels with the held op and is replaced on the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (accept) begin
            illegal_q <= !dec_legal;
        end
    end

    assign ctrl.illegal = illegal_q;
`else
    logic unused_legal;
    assign unused_legal = dec_legal;
    assign ctrl.illegal = 1'b0;
`endif

    assign ctrl.in_ready  = ready && rst_n;
    assign ctrl.out_valid = (state == DONE);
    assign ctrl.alu_bus   = bus_q;
    assign ctrl.use_imm   = use_imm_q;
    assign ctrl.imm_ext   = imm_q;
    assign ctrl.rd        = rd_q;
    assign ctrl.rs1       = rs1_q;
    assign ctrl.rs2       = rs2_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// tb_alu_ctrl_decoder: randomized and directed checks of the decode/issue stage against a behavioural model.
// Latency: model expects out_valid lat cycles after the accept edge.
// Backpressure: exercises out_ready stalls, back-to-back issue and reset aborts.
module tb_alu_ctrl_decoder;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_ctrl_decoder_if ifc ();

    alu_ctrl_decoder #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] mk(input logic [4:0] op, input logic ib, input logic [3:0] r_d,
                                       input logic [3:0] r_s1, input logic [17:0] low);
        return {op, ib, r_d, r_s1, low};
    endfunction

    function automatic bit ref_illegal(input logic [31:0] ins);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        return (int'(ins[31:27]) > 20) || (ins[17:16] == 2'b11);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [14:0] ref_bus(input logic [31:0] ins);
        int op;
        op = int'(ins[31:27]);
        if (ref_illegal(ins)) return 15'h0;
        if (op <= 12) return 15'(1 << op);
        if (op == 14) return 15'h2000;
        if (op == 15) return 15'h4000;
        return 15'h0;
    endfunction

    function automatic int ref_lat(input logic [31:0] ins);
        int op;
        op = int'(ins[31:27]);
        if (ref_illegal(ins)) return 1;
        if (op == 2) return MUL_LAT;
        if (op == 3 || op == 4) return DIV_LAT;
        return 1;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int unsigned v;
        v = int'(ins[15:0]);
        if (ins[17:16] == 2'b01) return v;
        if (ins[17:16] == 2'b10) return v * 65536;
        if (v >= 32768) return v + 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [31:0] rand_single();
        logic [31:0] ins;
        int op;
        ins = $urandom;
        op  = $urandom_range(0, 17);
        if (op >= 2) op = op + 3;   // skip mul/div/mod
        ins[31:27] = 5'(op);
        return ins;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE, follow it through EXEC/DONE, stall `hold` cycles, then retire it.
    task automatic run_one(input logic [31:0] ins, input int hold, input string tag);
        logic [14:0] eb;
        int lat;
        int k;
        int guard;
        eb  = ref_bus(ins);
        lat = ref_lat(ins);
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_instr  = ins;
        #1;
        guard = 0;
        while (ifc.in_ready !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        n_checks++;
        if (ifc.in_ready !== 1'b1) $display("FAIL %s in_ready: got %b expected 1", tag, ifc.in_ready);
        else n_pass++;
        step();
        ifc.in_valid = 1'b0;
        ifc.in_instr = $urandom;
        k = 1;
        while (ifc.out_valid !== 1'b1 && k < lat + 4) begin
            n_checks++;
            if (ifc.alu_bus !== eb || ifc.in_ready !== 1'b0)
                $display("FAIL %s exec_hold: bus %h in_ready %b expected bus %h in_ready 0",
                         tag, ifc.alu_bus, ifc.in_ready, eb);
            else n_pass++;
            step();
            k++;
        end
        n_checks++;
        if (k !== lat) $display("FAIL %s latency: got %0d expected %0d", tag, k, lat);
        else n_pass++;
        n_checks++;
        if (ifc.alu_bus !== eb || ifc.use_imm !== ins[26] || ifc.imm_ext !== ref_imm(ins) ||
            ifc.rd !== ins[25:22] || ifc.rs1 !== ins[21:18] || ifc.rs2 !== ins[17:14] ||
            ifc.illegal !== ref_illegal(ins))
            $display("FAIL %s fields: got bus %h imm %b ext %h rd %h rs1 %h rs2 %h ill %b expected bus %h imm %b ext %h rd %h rs1 %h rs2 %h ill %b",
                     tag, ifc.alu_bus, ifc.use_imm, ifc.imm_ext, ifc.rd, ifc.rs1, ifc.rs2, ifc.illegal,
                     eb, ins[26], ref_imm(ins), ins[25:22], ins[21:18], ins[17:14], ref_illegal(ins));
        else n_pass++;
        for (int h = 0; h < hold; h++) begin
            step();
            n_checks++;
            if (ifc.out_valid !== 1'b1 || ifc.alu_bus !== eb || ifc.imm_ext !== ref_imm(ins) || ifc.in_ready !== 1'b0)
                $display("FAIL %s stall_stable: valid %b bus %h ext %h in_ready %b expected 1 %h %h 0",
                         tag, ifc.out_valid, ifc.alu_bus, ifc.imm_ext, ifc.in_ready, eb, ref_imm(ins));
            else n_pass++;
        end
        ifc.out_ready = 1'b1;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b1) $display("FAIL %s done_ready: got %b expected 1", tag, ifc.in_ready);
        else n_pass++;
        step();
        ifc.out_ready = 1'b0;
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.alu_bus !== 15'h0)
            $display("FAIL %s retire_idle: valid %b bus %h expected 0 0000", tag, ifc.out_valid, ifc.alu_bus);
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_instr  = $urandom;
        ifc.out_ready = 1'b1;
        repeat (3) step();
        n_checks++;
        if (ifc.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", ifc.in_ready);
        else n_pass++;
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.alu_bus !== 15'h0 || ifc.use_imm !== 1'b0 || ifc.imm_ext !== 32'h0 ||
            ifc.rd !== 4'h0 || ifc.rs1 !== 4'h0 || ifc.rs2 !== 4'h0 || ifc.illegal !== 1'b0)
            $display("FAIL reset_outputs: valid %b bus %h imm %b ext %h rd %h rs1 %h rs2 %h ill %b expected all zero",
                     ifc.out_valid, ifc.alu_bus, ifc.use_imm, ifc.imm_ext, ifc.rd, ifc.rs1, ifc.rs2, ifc.illegal);
        else n_pass++;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        rst_n         = 1'b1;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", ifc.in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (ifc.out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", ifc.out_valid);
        else n_pass++;
    endtask

    task automatic test_directed();
        run_one(mk(5'd0,  1'b1, 4'd1, 4'd2, {2'b00, 16'hFFFB}), 0, "add_imm");
        run_one(mk(5'd3,  1'b0, 4'd3, 4'd4, {4'd5, 14'h0}),     1, "div");
        run_one(mk(5'd4,  1'b1, 4'd6, 4'd7, {2'b01, 16'h8001}), 0, "mod_zext");
        run_one(mk(5'd2,  1'b0, 4'd8, 4'd9, {4'd10, 14'h0}),    2, "mul");
        run_one(mk(5'd14, 1'b1, 4'd2, 4'd3, {2'b00, 16'h0010}), 0, "ld");
        run_one(mk(5'd15, 1'b1, 4'd4, 4'd5, {2'b00, 16'h0020}), 0, "st");
        run_one(mk(5'd13, 1'b0, 4'd0, 4'd0, 18'h0),             0, "nop");
        run_one(mk(5'd9,  1'b1, 4'd7, 4'd0, {2'b10, 16'h1234}), 0, "mov_high");
        run_one(mk(5'd18, 1'b1, 4'd0, 4'd0, {2'b00, 16'h0040}), 0, "branch");
        run_one(mk(5'd1,  1'b1, 4'd1, 4'd1, {2'b11, 16'h9000}), 0, "mod11");
    endtask

    task automatic test_illegal();
        run_one(mk(5'd25, 1'b0, 4'd3, 4'd4, {4'd5, 14'h0}), 1, "op25");
        run_one(mk(5'd31, 1'b1, 4'd1, 4'd2, {2'b00, 16'h0001}), 0, "op31");
        run_one(mk(5'd6,  1'b0, 4'd2, 4'd3, {4'd1, 14'h0}), 0, "after_illegal");
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 60; i++) begin
            ins        = $urandom;
            ins[31:27] = 5'($urandom_range(0, 31));
            run_one(ins, $urandom_range(0, 3), "random");
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] add_i;
        logic [31:0] sub_i;
        logic [31:0] cmp_i;
        int done_cnt;
        add_i = mk(5'd0, 1'b0, 4'd1, 4'd2, {4'd3, 14'h0});
        sub_i = mk(5'd1, 1'b0, 4'd4, 4'd5, {4'd6, 14'h0});
        cmp_i = mk(5'd5, 1'b0, 4'd0, 4'd7, {4'd8, 14'h0});
        done_cnt = 0;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.in_instr  = add_i;
        step();
        ifc.in_instr = sub_i;
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.alu_bus !== ref_bus(add_i))
            $display("FAIL bp_add: valid %b bus %h expected 1 %h", ifc.out_valid, ifc.alu_bus, ref_bus(add_i));
        else n_pass++;
        if (ifc.out_valid === 1'b1) done_cnt++;
        step();
        ifc.in_instr  = cmp_i;
        ifc.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1 || ifc.alu_bus !== ref_bus(sub_i) || ifc.rd !== 4'd4)
                $display("FAIL bp_sub_stall: in_ready %b valid %b bus %h rd %h expected 0 1 %h 4",
                         ifc.in_ready, ifc.out_valid, ifc.alu_bus, ifc.rd, ref_bus(sub_i));
            else n_pass++;
            step();
        end
        ifc.out_ready = 1'b1;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", ifc.in_ready);
        else n_pass++;
        if (ifc.out_valid === 1'b1) done_cnt++;
        step();
        ifc.in_valid = 1'b0;
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.alu_bus !== ref_bus(cmp_i) || ifc.rs1 !== 4'd7)
            $display("FAIL bp_cmp: valid %b bus %h rs1 %h expected 1 %h 7", ifc.out_valid, ifc.alu_bus, ifc.rs1, ref_bus(cmp_i));
        else n_pass++;
        if (ifc.out_valid === 1'b1) done_cnt++;
        step();
        ifc.out_ready = 1'b0;
        n_checks++;
        if (done_cnt !== 3 || ifc.out_valid !== 1'b0)
            $display("FAIL bp_completions: got %0d valid %b expected 3 0", done_cnt, ifc.out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev;
        logic [31:0] cur;
        ifc.out_ready = 1'b1;
        cur = rand_single();
        ifc.in_valid = 1'b1;
        ifc.in_instr = cur;
        step();
        for (int i = 0; i < 24; i++) begin
            prev = cur;
            cur  = rand_single();
            ifc.in_instr = cur;
            #1;
            n_checks++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b1 || ifc.alu_bus !== ref_bus(prev) ||
                ifc.imm_ext !== ref_imm(prev) || ifc.rd !== prev[25:22] || ifc.use_imm !== prev[26])
                $display("FAIL b2b_%0d: valid %b ready %b bus %h ext %h rd %h expected 1 1 %h %h %h",
                         i, ifc.out_valid, ifc.in_ready, ifc.alu_bus, ifc.imm_ext, ifc.rd,
                         ref_bus(prev), ref_imm(prev), prev[25:22]);
            else n_pass++;
            step();
        end
        ifc.in_valid = 1'b0;
        n_checks++;
        if (ifc.out_valid !== 1'b1 || ifc.alu_bus !== ref_bus(cur))
            $display("FAIL b2b_last: valid %b bus %h expected 1 %h", ifc.out_valid, ifc.alu_bus, ref_bus(cur));
        else n_pass++;
        step();
        ifc.out_ready = 1'b0;
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.alu_bus !== 15'h0)
            $display("FAIL b2b_idle: valid %b bus %h expected 0 0000", ifc.out_valid, ifc.alu_bus);
        else n_pass++;
    endtask

    // Start a long op, abort it with reset after `exec_cycles` EXEC cycles, check nothing completes.
    task automatic abort_op(input logic [31:0] ins, input int exec_cycles, input string tag);
        ifc.out_ready = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_instr  = ins;
        step();
        ifc.in_valid = 1'b0;
        for (int c = 1; c < exec_cycles; c++) step();
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.alu_bus !== ref_bus(ins))
            $display("FAIL %s pre_abort: valid %b bus %h expected 0 %h", tag, ifc.out_valid, ifc.alu_bus, ref_bus(ins));
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ifc.in_ready !== 1'b0) $display("FAIL %s reset_ready: got %b expected 0", tag, ifc.in_ready);
        else n_pass++;
        step();
        n_checks++;
        if (ifc.out_valid !== 1'b0 || ifc.alu_bus !== 15'h0 || ifc.use_imm !== 1'b0 || ifc.imm_ext !== 32'h0 ||
            ifc.rd !== 4'h0 || ifc.rs1 !== 4'h0 || ifc.rs2 !== 4'h0)
            $display("FAIL %s aborted: valid %b bus %h imm %b ext %h rd %h rs1 %h rs2 %h expected all zero",
                     tag, ifc.out_valid, ifc.alu_bus, ifc.use_imm, ifc.imm_ext, ifc.rd, ifc.rs1, ifc.rs2);
        else n_pass++;
        rst_n         = 1'b1;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            n_checks++;
            if (ifc.out_valid !== 1'b0) $display("FAIL %s no_completion_%0d: got %b expected 0", tag, c, ifc.out_valid);
            else n_pass++;
            step();
        end
        ifc.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        abort_op(mk(5'd2, 1'b1, 4'd9, 4'd3, {2'b00, 16'hABCD}), 1, "abort_mul");
        abort_op(mk(5'd3, 1'b1, 4'd5, 4'd6, {2'b10, 16'h00FF}), 2, "abort_div");
        abort_op(mk(5'd4, 1'b0, 4'd7, 4'd8, {4'd9, 14'h0}),     3, "abort_mod");
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_instr  = '0;
        ifc.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
